// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU-side memory-access controller.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 32;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE,
    RB_STROBE,
    RB_HOLD
  } state_e;

endpackage

// File: rtl/mem_strobe_gen.sv
// Single-pulse RAM strobe generator: on start, raises exactly one of the
// write/read strobes for STROBE_CYCLES cycles; finished marks the last one.
module mem_strobe_gen #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic is_write,
  output logic strobe_wr,
  output logic strobe_rd,
  output logic finished
);

  if (STROBE_CYCLES < 1) begin : g_bad_strobe_cycles
    $error("mem_strobe_gen: STROBE_CYCLES must be at least 1");
  end

  localparam int unsigned CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES - 1);

  logic             wr_q;
  logic             rd_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= '0;
    end else if (start) begin
      wr_q  <= is_write;
      rd_q  <= ~is_write;
      cnt_q <= CNT_LOAD;
    end else if (wr_q || rd_q) begin
      if (cnt_q == '0) begin
        wr_q <= 1'b0;
        rd_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign strobe_wr = wr_q;
  assign strobe_rd = rd_q;
  assign finished  = (wr_q || rd_q) && (cnt_q == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Sequential RAM access controller: SETUP / STROBE / HOLD / DONE sequencing
// with registered address, data and strobes. Optional write read-back check
// enabled by MEM_CTRL_WRITE_READBACK_EN (adds wb_err).
module mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W        = DATA_W_DEFAULT,
  parameter int          STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_CTRL_WRITE_READBACK_EN
  ,
  output logic              wb_err
`endif
);

  state_e            state_q;
  logic              op_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              sg_start;
  logic              sg_is_write;
  logic              sg_finished;
`ifdef MEM_CTRL_WRITE_READBACK_EN
  logic              wb_err_q;
`endif

  // Strobe starts one cycle ahead so it rises on the same edge as STROBE entry.
  always_comb begin
    sg_start    = 1'b0;
    sg_is_write = op_q;
    if (state_q == SETUP) begin
      sg_start = 1'b1;
    end
`ifdef MEM_CTRL_WRITE_READBACK_EN
    if (state_q == HOLD && op_q == OP_WRITE) begin
      sg_start    = 1'b1;
      sg_is_write = OP_READ;
    end
`endif
  end

  mem_strobe_gen #(
    .STROBE_CYCLES(STROBE_CYCLES)
  ) u_strobe (
    .clk      (clk),
    .clr      (clr),
    .start    (sg_start),
    .is_write (sg_is_write),
    .strobe_wr(mem_write),
    .strobe_rd(mem_read),
    .finished (sg_finished)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      op_q     <= OP_READ;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef MEM_CTRL_WRITE_READBACK_EN
      wb_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_q    <= we;
            busy_q  <= 1'b1;
            state_q <= SETUP;
`ifdef MEM_CTRL_WRITE_READBACK_EN
            wb_err_q <= 1'b0;
`endif
          end
        end
        SETUP: state_q <= STROBE;
        STROBE: begin
          if (sg_finished) state_q <= HOLD;
        end
        HOLD: begin
`ifdef MEM_CTRL_WRITE_READBACK_EN
          if (op_q == OP_WRITE) begin
            state_q <= RB_STROBE;
          end else begin
            rdata_q <= mem_rdata;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
`else
          if (op_q == OP_READ) rdata_q <= mem_rdata;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
`endif
        end
`ifdef MEM_CTRL_WRITE_READBACK_EN
        RB_STROBE: begin
          if (sg_finished) state_q <= RB_HOLD;
        end
        RB_HOLD: begin
          if (mem_rdata != wdata_q) wb_err_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`ifdef MEM_CTRL_WRITE_READBACK_EN
  assign wb_err    = wb_err_q;
`endif

endmodule
